bist_cut_target: RTL and testbench
==================================

// Module: bist_cut_target
// PURPOSE
//  Circuit-under-test responder for the BIST engine: accepts the 4-bit drive vector, advances an
//  internal state register every cycle, returns state_o to the checker one cycle after drive.
//  Includes run-time stuck-at/single-flip fault injection, so the BIST fail path can be exercised,
//  and a MISR signature of the state stream for cross-checking the pass/fail verdict.
// PARAMETERS
//  W          4         state/drive width (>=2, power of 2)
//  SIG_W      16        MISR width (>W)
//  MISR_POLY  16'h1021  MISR feedback polynomial (taps XORed in when sig MSB=1)
//  MISR_SEED  16'h0000  signature value after reset / sig_clr_i
// PORTS
//  clk            in   1          clock, all state on rising edge
//  trst           in   1          reset, asynchronous, active-high
//  drive_i        in   W          stimulus vector from BIST
//  hold_i         in   1          1: freeze state, MISR, counter, pending flip
//  fault_we_i     in   1          1: load fault_mode_i/fault_bit_i this cycle
//  fault_mode_i   in   2          00 none, 01 stuck-at-0, 10 stuck-at-1, 11 flip-once
//  fault_bit_i    in   log2(W)    target state bit
//  sig_clr_i      in   1          1: MISR<=MISR_SEED, cycle count<=0
//  state_o        out  W          registered CUT state (to BIST state_i)
//  sig_o          out  SIG_W      MISR signature
//  cycle_cnt_o    out  8          count of state updates since clear, saturating
//  fault_active_o out  1          1 while stuck-at armed or flip pending
// BEHAVIOUR
//  Reset (trst=1, async): state_o=0, sig_o=MISR_SEED, cycle_cnt_o=0, fault FSM=IDLE, fault_active_o=0.
//  Update cycle = any cycle with hold_i=0. Latency drive_i -> state_o: 1 cycle.
//  Next state: raw = {state[W-2:0],state[W-1]} ^ drive_i; stored value = raw after fault applied:
//   SA0: bit fault_bit forced 0; SA1: forced 1; FLIP_PEND: bit fault_bit inverted; else raw.
//  Fault FSM (registered mode/bit):
//   IDLE -(we, mode 01/10)-> STUCK; IDLE -(we, mode 11)-> FLIP_PEND; any -(we, mode 00)-> IDLE.
//   STUCK: applied on every update until rewritten. we in STUCK/FLIP_DONE reloads per mode.
//   FLIP_PEND -(first update cycle)-> FLIP_DONE (inversion applied exactly on that update).
//   FLIP_DONE: no effect; re-armed only by new we with mode 11.
//   fault_active_o = (STUCK | FLIP_PEND), registered.
//  fault_we_i in an update cycle: config takes effect from the NEXT update; current update uses old config.
//  hold_i=1: FLIP_PEND stays pending; fault_we_i still accepted.
//  MISR (update cycles): sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1]?MISR_POLY:0) ^ zext(state_o),
//   state_o taken pre-update value.
//  cycle_cnt_o: +1 per update cycle, saturates at 255.
//  sig_clr_i: priority over update for MISR and counter (both take clear value); state still updates.
//  Reset mid-operation: all state incl. pending flip dropped immediately; no carry-over.
// TESTING
//  1 Reset, drive 0001 two cycles -> state_o 0001 then 0011; cycle_cnt_o 1 then 2.
//  2 From 0011 hold_i=1 for 5 cycles with random drive -> state_o, sig_o, cycle_cnt_o unchanged.
//  3 Reset, we mode 10 bit 3, drive 0000 -> state_o 1000, then 1001; fault_active_o=1 throughout.
//  4 Reset, we mode 11 bit 0 with hold_i=1 3 cycles, then drive 0000 -> state_o 0001, next 0010,
//    fault_active_o 1->0 on the flip update.
//  5 sig_clr_i with state_o=0011, next cycle update -> sig_o=0x0003; clr+update same cycle -> sig_o=seed.
//  6 300 update cycles, no clear -> cycle_cnt_o=255; trst pulse mid-run -> all outputs reset values.

Source files
------------

// File: rtl/bist_cut_target_if.sv
// Bus between the BIST engine (master) and the circuit-under-test responder (slave).
// fault_state_dbg exposes the fault FSM state so checkers can bind to it.
interface bist_cut_target_if #(
    parameter int W     = 4,
    parameter int SIG_W = 16
);
    localparam int BW = $clog2(W);

    logic [W-1:0]     drive_i;
    logic             hold_i;
    logic             fault_we_i;
    logic [1:0]       fault_mode_i;
    logic [BW-1:0]    fault_bit_i;
    logic             sig_clr_i;
    logic [W-1:0]     state_o;
    logic [SIG_W-1:0] sig_o;
    logic [7:0]       cycle_cnt_o;
    logic             fault_active_o;
    logic [1:0]       fault_state_dbg;

    modport master (
        output drive_i, hold_i, fault_we_i, fault_mode_i, fault_bit_i, sig_clr_i,
        input  state_o, sig_o, cycle_cnt_o, fault_active_o, fault_state_dbg
    );

    modport slave (
        input  drive_i, hold_i, fault_we_i, fault_mode_i, fault_bit_i, sig_clr_i,
        output state_o, sig_o, cycle_cnt_o, fault_active_o, fault_state_dbg
    );
endinterface

// File: rtl/bist_cut_target.sv
// CUT responder for the BIST engine: rotating-XOR state register with run-time fault
// injection, a MISR over the state stream and a saturating update counter.
module bist_cut_target #(
    parameter int               W         = 4,
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [SIG_W-1:0] MISR_SEED = 16'h0000
) (
    input logic              clk,
    input logic              trst,
    bist_cut_target_if.slave bus
);
    localparam int BW = $clog2(W);

    typedef enum logic [1:0] {
        F_IDLE      = 2'd0,
        F_STUCK     = 2'd1,
        F_FLIP_PEND = 2'd2,
        F_FLIP_DONE = 2'd3
    } fault_state_t;

    fault_state_t     fault_state, fault_next;
    logic             stuck_val;
    logic [BW-1:0]    fault_bit;
    logic [W-1:0]     state_q, state_next, raw;
    logic [SIG_W-1:0] sig_q, misr_next;
    logic [7:0]       cnt_q;
    logic             update;

    assign update = ~bus.hold_i;

    // Fault FSM: a config write always wins over the flip-consumed transition,
    // but the update in the same cycle still sees the old registered state.
    always_comb begin
        fault_next = fault_state;
        if (update && fault_state == F_FLIP_PEND)
            fault_next = F_FLIP_DONE;
        if (bus.fault_we_i) begin
            case (bus.fault_mode_i)
                2'b00:   fault_next = F_IDLE;
                2'b01:   fault_next = F_STUCK;
                2'b10:   fault_next = F_STUCK;
                default: fault_next = F_FLIP_PEND;
            endcase
        end
    end

    always_comb begin
        raw        = {state_q[W-2:0], state_q[W-1]} ^ bus.drive_i;
        state_next = raw;
        case (fault_state)
            F_STUCK:     state_next[fault_bit] = stuck_val;
            F_FLIP_PEND: state_next[fault_bit] = ~raw[fault_bit];
            default:     state_next = raw;
        endcase
    end

    // MISR absorbs the state value as it stood before this update.
    always_comb begin
        misr_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
                  ^ SIG_W'(state_q);
    end

    always_ff @(posedge clk or posedge trst) begin
        if (trst) begin
            fault_state <= F_IDLE;
            stuck_val   <= 1'b0;
            fault_bit   <= '0;
        end else begin
            fault_state <= fault_next;
            if (bus.fault_we_i) begin
                stuck_val <= (bus.fault_mode_i == 2'b10);
                fault_bit <= bus.fault_bit_i;
            end
        end
    end

    always_ff @(posedge clk or posedge trst) begin
        if (trst) begin
            state_q <= '0;
            sig_q   <= MISR_SEED;
            cnt_q   <= 8'd0;
        end else begin
            if (update)
                state_q <= state_next;
            if (bus.sig_clr_i) begin
                sig_q <= MISR_SEED;
                cnt_q <= 8'd0;
            end else if (update) begin
                sig_q <= misr_next;
                if (cnt_q != 8'd255)
                    cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign bus.state_o         = state_q;
    assign bus.sig_o           = sig_q;
    assign bus.cycle_cnt_o     = cnt_q;
    assign bus.fault_active_o  = (fault_state == F_STUCK) || (fault_state == F_FLIP_PEND);
    assign bus.fault_state_dbg = fault_state;
endmodule

// File: tb/tb_bist_cut_target.sv
// Bench for bist_cut_target: directed scenarios plus random traffic, with a scoreboard
// fed by an arithmetic reference model and a monitor that compares every cycle.
module tb_bist_cut_target;
  localparam int W     = 4;
  localparam int SIG_W = 16;
  localparam int BW    = $clog2(W);
  localparam int EW    = W + SIG_W + 8 + 1;
  localparam int POLY  = 'h1021;
  localparam int SEED  = 'h0000;

  logic clk;
  logic trst;

  bist_cut_target_if #(.W(W), .SIG_W(SIG_W)) bus ();

  bist_cut_target #(
    .W(W), .SIG_W(SIG_W), .MISR_POLY(16'h1021), .MISR_SEED(16'h0000)
  ) dut (
    .clk (clk),
    .trst(trst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0] exp_q[$];
  string         tag_q[$];

  // reference model: 0 none, 1 stuck-0, 2 stuck-1, 3 flip pending, 4 flip used
  int m_state, m_sig, m_cnt, m_kind, m_bit;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  function automatic logic [EW-1:0] model_vec();
    logic active;
    active = (m_kind == 1) || (m_kind == 2) || (m_kind == 3);
    return {W'(m_state), SIG_W'(m_sig), 8'(m_cnt), active};
  endfunction

  task automatic model_reset();
    m_state = 0; m_sig = SEED; m_cnt = 0; m_kind = 0; m_bit = 0;
  endtask

  task automatic model_step(input int d, input bit hold, input bit we,
                            input int mode, input int fbit, input bit clr);
    int nxt, shifted;
    if (!hold) begin
      nxt = ((m_state * 2) % (1 << W)) + (m_state / (1 << (W - 1)));
      nxt = nxt ^ d;
      if (m_kind == 1) nxt = nxt & ~(1 << m_bit);
      if (m_kind == 2) nxt = nxt | (1 << m_bit);
      if (m_kind == 3) begin
        nxt    = nxt ^ (1 << m_bit);
        m_kind = 4;
      end
      shifted = (m_sig * 2) % (1 << SIG_W);
      if (m_sig >= (1 << (SIG_W - 1))) shifted = shifted ^ POLY;
      m_sig   = shifted ^ m_state;
      m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_state = nxt;
    end
    if (clr) begin
      m_sig = SEED;
      m_cnt = 0;
    end
    if (we) begin
      m_kind = mode;
      m_bit  = fbit;
    end
  endtask

  // driver
  task automatic step(input int d, input bit hold, input bit we,
                      input int mode, input int fbit, input bit clr, input string tag);
    @(negedge clk);
    trst             = 1'b0;
    bus.drive_i      = W'(d);
    bus.hold_i       = hold;
    bus.fault_we_i   = we;
    bus.fault_mode_i = 2'(mode);
    bus.fault_bit_i  = BW'(fbit);
    bus.sig_clr_i    = clr;
    model_step(d, hold, we, mode, fbit, clr);
    @(posedge clk);
    #1;
    exp_q.push_back(model_vec());
    tag_q.push_back(tag);
  endtask

  // Reset asserted between edges so the async path is exercised, held across one edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    trst             = 1'b1;
    bus.drive_i      = '0;
    bus.hold_i       = 1'b0;
    bus.fault_we_i   = 1'b0;
    bus.fault_mode_i = 2'b00;
    bus.fault_bit_i  = '0;
    bus.sig_clr_i    = 1'b0;
    model_reset();
    #1;
    check("reset_state", int'(bus.state_o), 0);
    check("reset_sig", int'(bus.sig_o), SEED);
    check("reset_cnt", int'(bus.cycle_cnt_o), 0);
    check("reset_active", int'(bus.fault_active_o), 0);
    @(posedge clk);
    #1;
    exp_q.push_back(model_vec());
    tag_q.push_back("in_reset");
  endtask

  // monitor: output is valid every cycle the scoreboard holds an expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".state"}, int'(bus.state_o), int'(e[EW-1 -: W]));
      check({t, ".sig"}, int'(bus.sig_o), int'(e[SIG_W+8 -: SIG_W]));
      check({t, ".cnt"}, int'(bus.cycle_cnt_o), int'(e[8:1]));
      check({t, ".active"}, int'(bus.fault_active_o), int'(e[0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    trst = 1'b1;
    bus.drive_i = '0; bus.hold_i = 1'b0; bus.fault_we_i = 1'b0;
    bus.fault_mode_i = 2'b00; bus.fault_bit_i = '0; bus.sig_clr_i = 1'b0;
    model_reset();

    // basic rotate-xor
    do_reset();
    step(1, 0, 0, 0, 0, 0, "t1a");
    check("t1_state0", int'(bus.state_o), 4'b0001);
    check("t1_cnt0", int'(bus.cycle_cnt_o), 1);
    step(1, 0, 0, 0, 0, 0, "t1b");
    check("t1_state1", int'(bus.state_o), 4'b0011);
    check("t1_cnt1", int'(bus.cycle_cnt_o), 2);

    // hold freezes everything
    for (int i = 0; i < 5; i++) step($urandom_range(0, 15), 1, 0, 0, 0, 0, "t2_hold");
    check("t2_state", int'(bus.state_o), 4'b0011);
    check("t2_cnt", int'(bus.cycle_cnt_o), 2);

    // signature clear; drive 0101 keeps state at 0011 during the clear cycle
    step(5, 0, 0, 0, 0, 1, "t5_clr");
    check("t5_sig_clr_upd", int'(bus.sig_o), SEED);
    check("t5_cnt_clr", int'(bus.cycle_cnt_o), 0);
    step(0, 0, 0, 0, 0, 0, "t5_upd");
    check("t5_sig_after", int'(bus.sig_o), 'h0003);

    // stuck-at-1 on bit 3
    do_reset();
    step(0, 1, 1, 2, 3, 0, "t3_cfg");
    check("t3_active_cfg", int'(bus.fault_active_o), 1);
    step(0, 0, 0, 0, 0, 0, "t3a");
    check("t3_state0", int'(bus.state_o), 4'b1000);
    step(0, 0, 0, 0, 0, 0, "t3b");
    check("t3_state1", int'(bus.state_o), 4'b1001);
    check("t3_active", int'(bus.fault_active_o), 1);

    // flip-once on bit 0, armed during hold
    do_reset();
    step(0, 1, 1, 3, 0, 0, "t4_cfg");
    step(0, 1, 0, 0, 0, 0, "t4_hold");
    step(0, 1, 0, 0, 0, 0, "t4_hold");
    check("t4_active_pend", int'(bus.fault_active_o), 1);
    step(0, 0, 0, 0, 0, 0, "t4_flip");
    check("t4_state_flip", int'(bus.state_o), 4'b0001);
    check("t4_active_done", int'(bus.fault_active_o), 0);
    step(0, 0, 0, 0, 0, 0, "t4_next");
    check("t4_state_next", int'(bus.state_o), 4'b0010);

    // config write during an update only affects the following update
    step(0, 0, 1, 1, 1, 0, "wr_same_cycle");
    step(15, 0, 0, 0, 0, 0, "wr_next_cycle");

    // a pending flip does not survive reset
    step(0, 1, 1, 3, 2, 0, "arm_then_reset");
    do_reset();
    step(0, 0, 0, 0, 0, 0, "no_carry");
    check("no_carry_state", int'(bus.state_o), 0);

    // random traffic
    for (int i = 0; i < 250; i++) begin
      step($urandom_range(0, 15), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
           $urandom_range(0, W - 1), ($urandom_range(0, 15) == 0), "rand");
    end

    // counter saturation, then async reset mid-run
    do_reset();
    for (int i = 0; i < 300; i++) step($urandom_range(0, 15), 0, 0, 0, 0, 0, "sat");
    check("t6_cnt_sat", int'(bus.cycle_cnt_o), 255);
    do_reset();
    step(0, 1, 0, 0, 0, 0, "post_reset");

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
